// File: rtl/lmsm_sequencer.sv
// LM/SM expander between IF/ID and the control decoder: turns each multi-register
// load/store into single-register LW/SW micro-ops and passes everything else through.
module lmsm_sequencer #(
  parameter int IW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  input  logic          instr_in_valid,
  input  logic          stall_in,
  output logic [IW-1:0] instr_out,
  output logic          instr_out_valid,
  output logic          fetch_stall,
  output logic          busy,
  output logic          uop_last
);

  localparam int RW = $clog2(NREG);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     instr_out_q, instr_out_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              sm_q, sm_d;
  logic [RW-1:0]     base_q, base_d;
  logic [NREG-1:0]   list_q, list_d;
  logic [NREG-1:0]   mask_q, mask_d;

  logic              is_lmsm;
  logic              src_sm;
  logic [RW-1:0]     src_base;
  logic [NREG-1:0]   src_list;
  logic [NREG-1:0]   src_mask;
  logic [NREG-1:0]   base_bit;
  logic [NREG-1:0]   cand;
  logic [NREG-1:0]   rem;
  logic [RW-1:0]     idx;
  logic              found;
  logic [5:0]        off6;
  logic [IW-1:0]     uop;
  logic              unused_bit8;

  assign unused_bit8 = instr_in[8];
  assign is_lmsm     = (instr_in[15:13] == 3'b110);

  // In IDLE the micro-op is formed straight from the incoming instruction so it
  // can be issued in the same cycle it is accepted.
  always_comb begin
    if (state_q == IDLE) begin
      src_sm   = instr_in[12];
      src_base = instr_in[11:9];
      src_list = instr_in[NREG-1:0];
      src_mask = instr_in[NREG-1:0];
    end else begin
      src_sm   = sm_q;
      src_base = base_q;
      src_list = list_q;
      src_mask = mask_q;
    end
  end

  // LM keeps the base register for last unless it is the only one left.
  always_comb begin
    base_bit = '0;
    base_bit[src_base] = 1'b1;
    cand = src_mask;
    if (!src_sm && ((src_mask & base_bit) != '0) && ((src_mask & ~base_bit) != '0))
      cand = src_mask & ~base_bit;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (cand[i] && !found) begin
        idx   = i[RW-1:0];
        found = 1'b1;
      end
    end
    rem = src_mask;
    rem[idx] = 1'b0;
    off6 = '0;
    for (int j = 0; j < NREG; j++) begin
      if ((j < int'(idx)) && src_list[j])
        off6 = off6 + 6'd1;
    end
    uop = {(src_sm ? 4'b0101 : 4'b0100), idx, src_base, off6};
  end

  always_comb begin
    state_d     = state_q;
    instr_out_d = instr_out_q;
    valid_d     = valid_q;
    last_d      = last_q;
    sm_d        = sm_q;
    base_d      = base_q;
    list_d      = list_q;
    mask_d      = mask_q;
    case (state_q)
      IDLE: begin
        if (!instr_in_valid) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (!is_lmsm) begin
          instr_out_d = instr_in;
          valid_d     = 1'b1;
          last_d      = 1'b1;
        end else if (src_mask == '0) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          instr_out_d = uop;
          valid_d     = 1'b1;
          last_d      = (rem == '0);
          if (rem != '0) begin
            state_d = SEQ;
            sm_d    = src_sm;
            base_d  = src_base;
            list_d  = src_list;
            mask_d  = rem;
          end
        end
      end
      SEQ: begin
        instr_out_d = uop;
        valid_d     = 1'b1;
        mask_d      = rem;
        last_d      = (rem == '0);
        if (rem == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_out_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      sm_q        <= 1'b0;
      base_q      <= '0;
      list_q      <= '0;
      mask_q      <= '0;
    end else if (!stall_in) begin
      state_q     <= state_d;
      instr_out_q <= instr_out_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      sm_q        <= sm_d;
      base_q      <= base_d;
      list_q      <= list_d;
      mask_q      <= mask_d;
    end
  end

  assign instr_out       = instr_out_q;
  assign instr_out_valid = valid_q;
  assign uop_last        = last_q;
  assign busy            = (state_q == SEQ);
  assign fetch_stall     = stall_in | (state_q == SEQ);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: pass-through, LM/SM expansion, base deferral,
// stalls and asynchronous reset, with hand-computed expected micro-ops.
module tb_lmsm_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_in_valid;
  logic        stall_in;
  logic [15:0] instr_out;
  logic        instr_out_valid;
  logic        fetch_stall;
  logic        busy;
  logic        uop_last;

  int n_assert;
  int n_fail;

  logic [15:0] full_exp [8];

  lmsm_sequencer #(.IW(16), .NREG(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (instr_in),
    .instr_in_valid  (instr_in_valid),
    .stall_in        (stall_in),
    .instr_out       (instr_out),
    .instr_out_valid (instr_out_valid),
    .fetch_stall     (fetch_stall),
    .busy            (busy),
    .uop_last        (uop_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs at once: instr_out, valid, uop_last, fetch_stall, busy.
  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_v,
                         input logic e_last, input logic e_fs, input logic e_busy);
    chk({tag, ".out"},   instr_out, e_out);
    chk({tag, ".valid"}, {15'd0, instr_out_valid}, {15'd0, e_v});
    chk({tag, ".last"},  {15'd0, uop_last}, {15'd0, e_last});
    chk({tag, ".fstall"}, {15'd0, fetch_stall}, {15'd0, e_fs});
    chk({tag, ".busy"},  {15'd0, busy}, {15'd0, e_busy});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    full_exp = '{16'h5000, 16'h5201, 16'h5402, 16'h5603,
                 16'h5804, 16'h5A05, 16'h5C06, 16'h5E07};
    rst = 1'b1; instr_in = 16'h0000; instr_in_valid = 1'b0; stall_in = 1'b0;
    #12;
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // pass-through
    instr_in = 16'h1234; instr_in_valid = 1'b1;
    step();
    chk_all("pass", 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);

    // LM R2, list 0x0B; next instruction waits upstream
    instr_in = 16'hC40B;
    step();
    chk_all("lm3.0", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b1);
    instr_in = 16'h1111;
    step();
    chk_all("lm3.1", 16'h4281, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("lm3.2", 16'h4682, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("lm3.next", 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0);

    // LM with base R1 in list: R1 deferred
    instr_in = 16'hC207;
    step();
    chk_all("defer.0", 16'h4040, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("defer.1", 16'h4442, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("defer.2", 16'h4241, 1'b1, 1'b1, 1'b0, 1'b0);

    // SM single register, then LM with empty list
    instr_in = 16'hDE80;
    step();
    chk_all("sm1", 16'h5FC0, 1'b1, 1'b1, 1'b0, 1'b0);
    instr_in = 16'hC000;
    step();
    chk_all("empty", 16'h5FC0, 1'b0, 1'b0, 1'b0, 1'b0);
    instr_in_valid = 1'b0;
    step();
    chk_all("idle", 16'h5FC0, 1'b0, 1'b0, 1'b0, 1'b0);

    // stall in the middle of a sequence
    instr_in = 16'hC40B; instr_in_valid = 1'b1;
    step();
    chk_all("stl.0", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("stl.1", 16'h4281, 1'b1, 1'b0, 1'b1, 1'b1);
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("stl.hold", 16'h4281, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    stall_in = 1'b0;
    step();
    chk_all("stl.2", 16'h4682, 1'b1, 1'b1, 1'b0, 1'b0);

    // stall in IDLE: nothing accepted
    instr_in = 16'h1234; stall_in = 1'b1;
    step();
    chk_all("stl.idle", 16'h4682, 1'b1, 1'b1, 1'b1, 1'b0);
    stall_in = 1'b0;
    step();
    chk_all("stl.idle.rel", 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-sequence
    instr_in = 16'hC40B;
    step();
    chk_all("rst.pre", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("rst.async", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    instr_in_valid = 1'b0;
    step();
    chk_all("rst.after", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // SM R0, full list: 8 micro-ops, no deferral
    instr_in = 16'hD0FF; instr_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("full", full_exp[i], 1'b1, (i == 7), (i < 7), (i < 7));
      if (i == 7) instr_in_valid = 1'b0;
    end
    step();
    chk_all("full.end", 16'h5E07, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
